// File: rtl/npu_feed_sequencer.sv
// npu_feed_sequencer: walks one conv layer's fmap/param buffers for NPUCore.
// Issues buffer reads (beat fastest, then output-channel group, then pixel),
// aligns MAC valid/adder_rst with the 1-cycle buffer latency, and tags each
// window through a fixed-depth pipe so out_valid lines up with MAC_data_out.
// Optional build macro: NPU_SEQ_PERF_EN adds perf_cycles/perf_stalls counters.
module npu_feed_sequencer #(
  parameter int BEATS    = 4,
  parameter int REPEATS  = 5,
  parameter int PIXELS   = 1024,
  parameter int PIPE_DLY = 10,
  parameter int FADDR_W  = 12,
  parameter int PADDR_W  = 5,
  parameter int PIX_W    = (PIXELS  > 1) ? $clog2(PIXELS)  : 1,
  parameter int REP_W    = (REPEATS > 1) ? $clog2(REPEATS) : 1,
  parameter int BEAT_W   = (BEATS   > 1) ? $clog2(BEATS)   : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hold,
  output logic               fmap_rd_en,
  output logic [FADDR_W-1:0] fmap_rd_addr,
  output logic               param_rd_en,
  output logic [PADDR_W-1:0] param_rd_addr,
  output logic               mac_in_valid,
  output logic               adder_rst,
  output logic               out_valid,
  output logic [PIX_W-1:0]   out_pix,
  output logic [REP_W-1:0]   out_rep,
`ifdef NPU_SEQ_PERF_EN
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_stalls,
`endif
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic             vld;
    logic [PIX_W-1:0] pix;
    logic [REP_W-1:0] rep;
  } tag_t;

  localparam bit BEATS_POW2 = (BEATS > 1) && ((BEATS & (BEATS - 1)) == 0);

  state_t state_q, state_d;

  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              rd_en;
  logic              beat_last, rep_last, pix_last, last_read;
  logic              accept;
  logic              last_tag;
  tag_t              tag_pipe [PIPE_DLY];

  assign accept    = (state_q == IDLE) && start;
  assign rd_en     = (state_q == RUN) && !hold;
  assign beat_last = (beat_q == BEAT_W'(BEATS - 1));
  assign rep_last  = (rep_q == REP_W'(REPEATS - 1));
  assign pix_last  = (pix_q == PIX_W'(PIXELS - 1));
  assign last_read = rd_en && beat_last && rep_last && pix_last;

  assign fmap_rd_en  = rd_en;
  assign param_rd_en = rd_en;

  // Power-of-two beat counts place the beat index in the low address bits.
  if (BEATS_POW2) begin : g_addr_cat
    assign fmap_rd_addr  = FADDR_W'({pix_q, beat_q});
    assign param_rd_addr = PADDR_W'({rep_q, beat_q});
  end else begin : g_addr_mul
    assign fmap_rd_addr  = FADDR_W'(pix_q) * FADDR_W'(BEATS) + FADDR_W'(beat_q);
    assign param_rd_addr = PADDR_W'(rep_q) * PADDR_W'(BEATS) + PADDR_W'(beat_q);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; DRAIN waits for the final window's tag to leave the pipe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_read) state_d = DRAIN;
      DRAIN:   if (last_tag) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  // Read walk counters: beat fastest, pixel slowest; frozen while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q  <= '0;
      rep_q  <= '0;
      beat_q <= '0;
    end else if (accept) begin
      pix_q  <= '0;
      rep_q  <= '0;
      beat_q <= '0;
    end else if (rd_en) begin
      if (beat_last) begin
        beat_q <= '0;
        if (rep_last) begin
          rep_q <= '0;
          pix_q <= pix_last ? '0 : pix_q + 1'b1;
        end else begin
          rep_q <= rep_q + 1'b1;
        end
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  // Delay the issued read by the buffer latency so valid meets its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_in_valid <= 1'b0;
      pix_d        <= '0;
      rep_d        <= '0;
      beat_d       <= '0;
    end else begin
      mac_in_valid <= rd_en;
      pix_d        <= pix_q;
      rep_d        <= rep_q;
      beat_d       <= beat_q;
    end
  end

  assign adder_rst = mac_in_valid && (beat_d == '0);

  // Window tag pipe: always shifts, so hold bubbles travel through as empty slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DLY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0].vld <= mac_in_valid && (beat_d == BEAT_W'(BEATS - 1));
      tag_pipe[0].pix <= (mac_in_valid && (beat_d == BEAT_W'(BEATS - 1))) ? pix_d : '0;
      tag_pipe[0].rep <= (mac_in_valid && (beat_d == BEAT_W'(BEATS - 1))) ? rep_d : '0;
      for (int i = 1; i < PIPE_DLY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign out_valid = tag_pipe[PIPE_DLY-1].vld;
  assign out_pix   = tag_pipe[PIPE_DLY-1].pix;
  assign out_rep   = tag_pipe[PIPE_DLY-1].rep;
  assign last_tag  = out_valid && (out_pix == PIX_W'(PIXELS - 1)) &&
                     (out_rep == REP_W'(REPEATS - 1));

`ifdef NPU_SEQ_PERF_EN
  // Busy and stall cycle counters; cleared per layer, saturating, idle after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 1'b1;
      if ((state_q == RUN) && hold && (perf_stalls != '1)) perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_npu_feed_sequencer.sv
// Bench for npu_feed_sequencer: a negedge monitor predicts reads, MAC strobes
// and window tags; tags are queued with their due cycle and popped on out_valid.
module tb_npu_feed_sequencer;
  localparam int BEATS    = 4;
  localparam int REPEATS  = 5;
  localparam int PIXELS   = 1024;
  localparam int PIPE_DLY = 10;
  localparam int NREADS   = BEATS * REPEATS * PIXELS;
  localparam int NWIN     = REPEATS * PIXELS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        fmap_rd_en, param_rd_en, mac_in_valid, adder_rst, out_valid, busy, done;
  logic [11:0] fmap_rd_addr;
  logic [4:0]  param_rd_addr;
  logic [9:0]  out_pix;
  logic [2:0]  out_rep;
`ifdef NPU_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  npu_feed_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .fmap_rd_en(fmap_rd_en), .fmap_rd_addr(fmap_rd_addr),
    .param_rd_en(param_rd_en), .param_rd_addr(param_rd_addr),
    .mac_in_valid(mac_in_valid), .adder_rst(adder_rst),
    .out_valid(out_valid), .out_pix(out_pix), .out_rep(out_rep),
`ifdef NPU_SEQ_PERF_EN
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int due; int pix; int rep;} tag_e;
  tag_e sbq[$];

  int errors = 0, checks = 0, cyc = 0;
  int ms = 0, mp = 0, mr = 0, mb = 0;
  bit prev_rd = 0, prev_b0 = 0;
  int n_reads, n_outv, n_adr, n_done, n_stall;
  int first_rd, last_rd, first_ov, last_ov, done_cyc, ov73, first_pix, first_rep;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats;
    n_reads = 0; n_outv = 0; n_adr = 0; n_done = 0; n_stall = 0;
    first_rd = -1; last_rd = -1; first_ov = -1; last_ov = -1;
    done_cyc = -1; ov73 = -1; first_pix = -1; first_rep = -1;
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin @(posedge clk); k++; end
    chk("done_timeout", 32'(n_done != 0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_outs", {fmap_rd_en, param_rd_en, mac_in_valid, adder_rst, out_valid,
                       busy, done, fmap_rd_addr, param_rd_addr, out_pix, out_rep}, 0);
      ms = 0; mp = 0; mr = 0; mb = 0; prev_rd = 0; prev_b0 = 0;
      sbq.delete();
    end else begin
      bit exp_rd, lastwin;
      exp_rd  = (ms == 1) && !hold;
      lastwin = 0;
      chk("fmap_rd_en", fmap_rd_en, exp_rd);
      chk("param_rd_en", param_rd_en, exp_rd);
      chk("busy", busy, (ms == 1 || ms == 2));
      chk("done", done, (ms == 3));
      if (ms == 1) begin
        chk("fmap_addr", fmap_rd_addr, mp * BEATS + mb);
        chk("param_addr", param_rd_addr, mr * BEATS + mb);
      end
      chk("mac_in_valid", mac_in_valid, prev_rd);
      chk("adder_rst", adder_rst, prev_rd && prev_b0);
      if (adder_rst) n_adr++;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        tag_e t;
        t = sbq.pop_front();
        chk("out_valid_hi", out_valid, 1);
        chk("out_pix", out_pix, t.pix);
        chk("out_rep", out_rep, t.rep);
        n_outv++;
        if (first_ov < 0) begin first_ov = cyc; first_pix = t.pix; first_rep = t.rep; end
        last_ov = cyc;
        if (t.pix == 7 && t.rep == 3) ov73 = cyc;
        lastwin = (t.pix == PIXELS - 1) && (t.rep == REPEATS - 1);
      end else begin
        chk("out_valid_lo", out_valid, 0);
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (ms == 1 && hold) n_stall++;
      prev_rd = exp_rd;
      prev_b0 = (mb == 0);
      case (ms)
        0: if (start) begin ms = 1; mp = 0; mr = 0; mb = 0; end
        1: if (exp_rd) begin
             bit last;
             n_reads++;
             if (first_rd < 0) first_rd = cyc;
             last_rd = cyc;
             if (mb == BEATS - 1) sbq.push_back('{cyc + 1 + PIPE_DLY, mp, mr});
             last = (mp == PIXELS - 1) && (mr == REPEATS - 1) && (mb == BEATS - 1);
             if (mb == BEATS - 1) begin
               mb = 0;
               if (mr == REPEATS - 1) begin mr = 0; mp = (mp == PIXELS - 1) ? 0 : mp + 1; end
               else mr++;
             end else mb++;
             if (last) ms = 2;
           end
        2: if (lastwin) ms = 3;
        default: ms = 0;
      endcase
    end
  end

  initial begin
    clear_stats();
    // Reset and a plain full layer
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    pulse_start();
    wait_done(25000);
    chk("t1_reads", n_reads, NREADS);
    chk("t1_read_span", last_rd - first_rd, NREADS - 1);
    chk("t1_outv", n_outv, NWIN);
    chk("t1_adr", n_adr, NWIN);
    chk("t1_done_cnt", n_done, 1);
    chk("t1_first_lat", first_ov - first_rd, 1 + (BEATS - 1) + PIPE_DLY);
    chk("t1_first_tag", {first_pix[15:0], first_rep[15:0]}, 0);
    chk("t1_done_after", done_cyc - last_ov, 1);
    chk("t1_busy_after", busy, 0);

    // Hold at beat 2 of window (7,3); stray starts in RUN and DRAIN
    clear_stats();
    pulse_start();
    begin
      int k = 0;
      while (!(fmap_rd_en && fmap_rd_addr == 12'd29 && param_rd_addr == 5'd13) && k < 2000) begin
        @(negedge clk); k++;
      end
      chk("t3_found_win", 32'(k < 2000), 1);
    end
    @(posedge clk); #1 hold = 1'b1;
    repeat (3) @(posedge clk);
    #1 hold = 1'b0;
    repeat (100) @(posedge clk);
    pulse_start();
    begin
      int k = 0;
      while (ms != 2 && k < 25000) begin @(negedge clk); k++; end
      chk("t4_drain_seen", 32'(ms == 2), 1);
    end
    pulse_start();
    wait_done(200);
    chk("t3_reads", n_reads, NREADS);
    chk("t3_outv", n_outv, NWIN);
    chk("t3_adr", n_adr, NWIN);
    chk("t3_stalls", n_stall, 3);
    chk("t3_win73_lat", ov73 - first_rd, BEATS * (7 * REPEATS + 3) + (BEATS - 1) + 1 + PIPE_DLY + 3);
    chk("t4_done_cnt", n_done, 1);
`ifdef NPU_SEQ_PERF_EN
    chk("t6_perf_stalls", perf_stalls, 3);
    chk("t6_perf_cycles", perf_cycles, NREADS + 3 + PIPE_DLY + 1);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_perf_hold", perf_cycles, NREADS + 3 + PIPE_DLY + 1);
`endif

    // Abort at read 1000, then a clean restart
    clear_stats();
    pulse_start();
    begin
      int k = 0;
      while (n_reads < 1000 && k < 2000) begin @(negedge clk); k++; end
      chk("t5_reached_1000", n_reads, 1000);
    end
    @(posedge clk); #1 rst = 1'b1;
    #2;
    chk("t5_abort_outs", {fmap_rd_en, mac_in_valid, adder_rst, out_valid, busy, done, fmap_rd_addr}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_stats();
    repeat (30) @(posedge clk);
    chk("t5_no_stale_ov", n_outv, 0);
    pulse_start();
    wait_done(25000);
    chk("t5_reads", n_reads, NREADS);
    chk("t5_outv", n_outv, NWIN);
    chk("t5_first_lat", first_ov - first_rd, 1 + (BEATS - 1) + PIPE_DLY);
    chk("t5_first_tag", {first_pix[15:0], first_rep[15:0]}, 0);
    chk("t5_done_cnt", n_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
